reset_sequencer: RTL
====================

// Module: reset_sequencer
// PURPOSE
//  Consumes the single global reset pulse from the startup reset generator and releases N
//  subsystem resets in order (e.g. clocking -> ADC/DAC interfaces -> filters -> servo).
//  Each stage is released only after the previous stage acknowledges ready.
//  Reports sequence completion, or the first stage that failed to acknowledge in time.
// PARAMETERS
//  N_STAGE   4       number of sequenced reset outputs (1..8)
//  HOLD_CYC  30'd100 cycles all outputs stay asserted after rst falls, and the gap before each release
//  TIMEOUT   30'd20000  max cycles to wait for a stage ack after its release (200 us at 100 MHz)
//  MAX_RETRY 2       full-sequence retries on timeout (RSTSEQ_RETRY_EN only)
// PORTS
//  clk_in     in   1        system clock
//  rst        in   1        asynchronous, active-high reset (from startup reset generator)
//  stage_ack  in   N_STAGE  per-stage ready/lock; may be asynchronous to clk_in
//  rst_out    out  N_STAGE  per-stage reset, active-high; bit 0 released first
//  seq_done   out  1        all stages released and acknowledged
//  seq_err    out  1        a stage ack timed out (sticky until rst)
//  err_stage  out  3        index of the stage that timed out; 0 when seq_err=0
// BEHAVIOUR
//  - Reset: while rst=1 all outputs take reset values immediately (async):
//    rst_out = all ones, seq_done=0, seq_err=0, err_stage=0, state=HOLD, counter=0, retry count=0.
//    Assertion is asynchronous; every release is synchronous to clk_in.
//  - stage_ack passes through a 2-FF synchroniser; the FSM sees ack 2 cycles late.
//  - FSM states: HOLD -> RELEASE -> WAIT_ACK -> (RELEASE of next stage | DONE | FAULT).
//    HOLD: 30-bit counter runs to HOLD_CYC-1, then goes to RELEASE with k=0.
//    RELEASE: clear rst_out[k] on this clock edge, reset the counter, go to WAIT_ACK.
//    WAIT_ACK: synchronised ack ignored for the first 3 cycles (blanking covers sync latency and stale ack).
//      Ack high after blanking: if k<N_STAGE-1, go to HOLD_GAP, then RELEASE k+1.
//      HOLD_GAP lasts HOLD_CYC cycles. If k=N_STAGE-1, go to DONE.
//      Counter reaches TIMEOUT-1 with no ack: go to FAULT.
//    DONE: seq_done=1 (registered, 1 cycle after final ack seen). Later ack drops are ignored.
//    FAULT: seq_err=1, err_stage=k. Stages <k stay released; stages >=k stay asserted.
//  - Latency with immediate acks: release of stage k+1 comes HOLD_CYC+3 cycles after release of k.
//  - Ack seen on the same cycle the counter hits TIMEOUT-1: ack wins.
//  - rst asserted mid-sequence: immediate return to reset values. The sequence restarts from HOLD
//    when rst falls. No partial state is kept.
//  - Counter saturates and never wraps. Parameter values above 2^30-1 are illegal.
// CONFIGURATION
//  RSTSEQ_RETRY_EN defined: on timeout, if retry count < MAX_RETRY, then:
//    re-assert all rst_out, increment retry count, return to HOLD.
//    seq_err stays 0 during retries.
//    Enter FAULT only after MAX_RETRY retries fail. err_stage then reports the last failing stage.
//  RSTSEQ_RETRY_EN undefined: the first timeout goes directly to FAULT. No retry counter is built.
// STRUCTURE
//  - Package rstseq_pkg: state enum (HOLD, RELEASE, WAIT_ACK, HOLD_GAP, DONE, FAULT),
//    CNT_W=30, ACK_BLANK=3, STAGE_W=3.
//  - Sub-module sync_2ff (parameterised width). One instance synchronises stage_ack[N_STAGE-1:0].
//  - Top level contains the FSM, the 30-bit counter, the stage index and the output registers.
// TESTING (HOLD_CYC=10, TIMEOUT=50, N_STAGE=4 unless noted)
//  1. Pulse rst for 5 cycles, with each ack driven high 4 cycles after its rst_out falls.
//     -> rst_out goes 1111 -> 1110 -> 1100 -> 1000 -> 0000 in order, then seq_done=1, seq_err=0.
//  2. stage_ack[2] held low.
//     -> 50 cycles after rst_out[2] falls: seq_err=1, err_stage=2, rst_out=1100, seq_done=0.
//  3. All acks tied high before release.
//     -> each stage still waits the 3-cycle blanking; stage k+1 releases 13 cycles after stage k.
//  4. Assert rst while in WAIT_ACK for stage 1.
//     -> rst_out=1111 in the same cycle (async), seq_done/seq_err=0.
//     -> after rst falls, the full sequence restarts from stage 0.
//  5. Ack rises exactly at counter=TIMEOUT-1 -> stage is accepted, and seq_err stays 0.
//  6. With RSTSEQ_RETRY_EN and MAX_RETRY=2, stage_ack[1] stuck low:
//     -> rst_out returns to 1111 twice; then seq_err=1, err_stage=1, rst_out=1110.

Source files
------------

// File: rtl/rstseq_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding,
// counter/stage widths, ack blanking length and a saturating-increment helper.
package rstseq_pkg;

   localparam int CNT_W     = 30;
   localparam int ACK_BLANK = 3;
   localparam int STAGE_W   = 3;

   typedef enum logic [2:0] {
      HOLD     = 3'd0,
      RELEASE  = 3'd1,
      WAIT_ACK = 3'd2,
      HOLD_GAP = 3'd3,
      DONE     = 3'd4,
      FAULT    = 3'd5
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      logic [CNT_W-1:0] result;
      if (value == {CNT_W{1'b1}}) begin
         result = value;
      end else begin
         result = value + CNT_W'(1);
      end
      return result;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus of independent level signals
// (each bit is synchronised on its own; no bus coherency is implied).
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // Metastability stage followed by the stable output stage.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         meta_q <= {WIDTH{1'b0}};
         sync_q <= {WIDTH{1'b0}};
      end else begin
         meta_q <= async_in;
         sync_q <= meta_q;
      end
   end

   assign sync_out = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Releases N_STAGE subsystem resets in order, each after the previous stage acks.
// Optional full-sequence retry on ack timeout is built when RSTSEQ_RETRY_EN is defined.
module reset_sequencer
   import rstseq_pkg::*;
#(
   parameter int               N_STAGE  = 4,
   parameter logic [CNT_W-1:0] HOLD_CYC = 30'd100,
   parameter logic [CNT_W-1:0] TIMEOUT  = 30'd20000
`ifdef RSTSEQ_RETRY_EN
   ,
   parameter int               MAX_RETRY = 2
`endif
) (
   input  logic               clk_in,
   input  logic               rst,
   input  logic [N_STAGE-1:0] stage_ack,
   output logic [N_STAGE-1:0] rst_out,
   output logic               seq_done,
   output logic               seq_err,
   output logic [2:0]         err_stage
);

   localparam logic [STAGE_W-1:0] LAST_K    = STAGE_W'(N_STAGE - 1);
   localparam logic [CNT_W-1:0]   HOLD_END  = HOLD_CYC - 30'd1;
   localparam logic [CNT_W-1:0]   TO_END    = TIMEOUT - 30'd1;
   localparam logic [CNT_W-1:0]   BLANK_END = CNT_W'(ACK_BLANK);
   // The gap is measured from the cycle the ack is seen to the next release edge,
   // so the accept and RELEASE cycles are part of it.
   localparam logic [CNT_W-1:0]   GAP_END   = (HOLD_CYC > 30'd3) ? (HOLD_CYC - 30'd3) : 30'd0;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [STAGE_W-1:0]   k_q, k_d;
   logic [N_STAGE-1:0]   rst_out_q, rst_out_d;
   logic                 seq_done_q, seq_done_d;
   logic                 seq_err_q, seq_err_d;
   logic [2:0]           err_stage_q, err_stage_d;
   logic [N_STAGE-1:0]   ack_sync_s;
   logic [N_STAGE-1:0]   sel_mask_s;
   logic                 ack_sel_s;
   logic                 retry_ok_s;

   sync_2ff #(
      .WIDTH (N_STAGE)
   ) u_ack_sync (
      .clk_in   (clk_in),
      .rst      (rst),
      .async_in (stage_ack),
      .sync_out (ack_sync_s)
   );

   // One-hot mask of the stage currently being released / waited on.
   always_comb begin
      sel_mask_s = {N_STAGE{1'b0}};
      for (int i = 0; i < N_STAGE; i++) begin
         if (k_q == STAGE_W'(i)) begin
            sel_mask_s[i] = 1'b1;
         end else begin
            sel_mask_s[i] = 1'b0;
         end
      end
      ack_sel_s = |(ack_sync_s & sel_mask_s);
   end

`ifdef RSTSEQ_RETRY_EN
   localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   logic [RETRY_W-1:0] retry_q, retry_d;

   // Retry budget: counts full-sequence restarts since the last rst.
   always_comb begin
      retry_ok_s = (retry_q < RETRY_W'(MAX_RETRY));
      retry_d    = retry_q;
      if ((state_q == WAIT_ACK) && !(ack_sel_s && (cnt_q >= BLANK_END)) &&
          (cnt_q >= TO_END) && retry_ok_s) begin
         retry_d = retry_q + RETRY_W'(1);
      end else begin
         retry_d = retry_q;
      end
   end

   // Retry counter register.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         retry_q <= {RETRY_W{1'b0}};
      end else begin
         retry_q <= retry_d;
      end
   end
`else
   assign retry_ok_s = 1'b0;
`endif

   // Next-state and next-output logic for the release sequence.
   always_comb begin
      state_d     = state_q;
      cnt_d       = sat_inc(cnt_q);
      k_d         = k_q;
      rst_out_d   = rst_out_q;
      seq_done_d  = seq_done_q;
      seq_err_d   = seq_err_q;
      err_stage_d = err_stage_q;
      case (state_q)
         HOLD: begin
            if (cnt_q >= HOLD_END) begin
               state_d = RELEASE;
               cnt_d   = {CNT_W{1'b0}};
               k_d     = {STAGE_W{1'b0}};
            end else begin
               state_d = HOLD;
            end
         end
         RELEASE: begin
            rst_out_d = rst_out_q & ~sel_mask_s;
            cnt_d     = {CNT_W{1'b0}};
            state_d   = WAIT_ACK;
         end
         WAIT_ACK: begin
            // Ack is checked before the timeout so a last-cycle ack is accepted.
            if (ack_sel_s && (cnt_q >= BLANK_END)) begin
               cnt_d = {CNT_W{1'b0}};
               if (k_q == LAST_K) begin
                  state_d    = DONE;
                  seq_done_d = 1'b1;
               end else begin
                  state_d = HOLD_GAP;
               end
            end else if (cnt_q >= TO_END) begin
               if (retry_ok_s) begin
                  state_d   = HOLD;
                  cnt_d     = {CNT_W{1'b0}};
                  k_d       = {STAGE_W{1'b0}};
                  rst_out_d = {N_STAGE{1'b1}};
               end else begin
                  state_d     = FAULT;
                  cnt_d       = cnt_q;
                  seq_err_d   = 1'b1;
                  err_stage_d = k_q;
               end
            end else begin
               state_d = WAIT_ACK;
            end
         end
         HOLD_GAP: begin
            if (cnt_q >= GAP_END) begin
               state_d = RELEASE;
               cnt_d   = {CNT_W{1'b0}};
               k_d     = k_q + 3'd1;
            end else begin
               state_d = HOLD_GAP;
            end
         end
         DONE: begin
            cnt_d = cnt_q;
         end
         FAULT: begin
            cnt_d = cnt_q;
         end
         default: begin
            state_d     = HOLD;
            cnt_d       = {CNT_W{1'b0}};
            k_d         = {STAGE_W{1'b0}};
            rst_out_d   = {N_STAGE{1'b1}};
            seq_done_d  = 1'b0;
            seq_err_d   = 1'b0;
            err_stage_d = 3'd0;
         end
      endcase
   end

   // State, counter and output registers; reset asserts all stage resets at once.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q     <= HOLD;
         cnt_q       <= {CNT_W{1'b0}};
         k_q         <= {STAGE_W{1'b0}};
         rst_out_q   <= {N_STAGE{1'b1}};
         seq_done_q  <= 1'b0;
         seq_err_q   <= 1'b0;
         err_stage_q <= 3'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         k_q         <= k_d;
         rst_out_q   <= rst_out_d;
         seq_done_q  <= seq_done_d;
         seq_err_q   <= seq_err_d;
         err_stage_q <= err_stage_d;
      end
   end

   assign rst_out   = rst_out_q;
   assign seq_done  = seq_done_q;
   assign seq_err   = seq_err_q;
   assign err_stage = err_stage_q;

endmodule
